// File: rtl/synth_pkg.sv
// Shared types and widths for the voice sequencer and its parameter mux.
// Pure declarations; no logic, no latency.
// Waveform selects are one-hot, one bit per generator waveform.
package synth_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_e;

    localparam int VOICE_W = 10;
    localparam int MIX_W   = 12;
    localparam int FREQ_W  = 16;
    localparam int PW_W    = 12;
    localparam int WSEL_W  = 4;

    localparam logic [WSEL_W-1:0] WSEL_TRI   = 4'b0001;
    localparam logic [WSEL_W-1:0] WSEL_SAW   = 4'b0010;
    localparam logic [WSEL_W-1:0] WSEL_PULSE = 4'b0100;
    localparam logic [WSEL_W-1:0] WSEL_NOISE = 4'b1000;

endpackage

// File: rtl/voice_param_mux.sv
// Selects one voice's control words from the packed per-voice vectors.
// Purely combinational, zero latency; no flow control.
// Outputs are forced to zero when en_i is low so an idle sequencer drives nothing.
module voice_param_mux
    import synth_pkg::*;
(
    input  logic                  en_i,
    input  logic [1:0]            idx_i,
    input  logic [3*FREQ_W-1:0]   freq_words_i,
    input  logic [3*PW_W-1:0]     pw_words_i,
    input  logic [3*WSEL_W-1:0]   wave_sels_i,
    input  logic [2:0]            sync_en_i,
    input  logic [2:0]            ring_en_i,
    output logic [FREQ_W-1:0]     freq_word_o,
    output logic [PW_W-1:0]       pw_word_o,
    output logic [WSEL_W-1:0]     wave_sel_o,
    output logic                  sync_o,
    output logic                  ring_mod_o
);

    always_comb begin
        freq_word_o = '0;
        pw_word_o   = '0;
        wave_sel_o  = '0;
        sync_o      = 1'b0;
        ring_mod_o  = 1'b0;
        if (en_i) begin
            case (idx_i)
                2'd0: begin
                    freq_word_o = freq_words_i[0*FREQ_W +: FREQ_W];
                    pw_word_o   = pw_words_i[0*PW_W +: PW_W];
                    wave_sel_o  = wave_sels_i[0*WSEL_W +: WSEL_W];
                    sync_o      = sync_en_i[0];
                    ring_mod_o  = ring_en_i[0];
                end
                2'd1: begin
                    freq_word_o = freq_words_i[1*FREQ_W +: FREQ_W];
                    pw_word_o   = pw_words_i[1*PW_W +: PW_W];
                    wave_sel_o  = wave_sels_i[1*WSEL_W +: WSEL_W];
                    sync_o      = sync_en_i[1];
                    ring_mod_o  = ring_en_i[1];
                end
                2'd2: begin
                    freq_word_o = freq_words_i[2*FREQ_W +: FREQ_W];
                    pw_word_o   = pw_words_i[2*PW_W +: PW_W];
                    wave_sel_o  = wave_sels_i[2*WSEL_W +: WSEL_W];
                    sync_o      = sync_en_i[2];
                    ring_mod_o  = ring_en_i[2];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/voice_sequencer.sv
// Walks each voice through the generator start/ready handshake per sample tick and sums the waves.
// Latency per voice: 1 ISSUE + WAIT cycles (+1 product register when VOICE_GAIN_EN is defined).
// Ticks while busy are dropped with overrun_o; a silent generator is abandoned after TIMEOUT_CYCLES.
module voice_sequencer
    import synth_pkg::*;
#(
    parameter int NUM_VOICES     = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef VOICE_GAIN_EN
    input  logic [3*WSEL_W-1:0]   gains_i,
`endif
    input  logic                  sample_tick_i,
    input  logic [3*FREQ_W-1:0]   freq_words_i,
    input  logic [3*PW_W-1:0]     pw_words_i,
    input  logic [3*WSEL_W-1:0]   wave_sels_i,
    input  logic [2:0]            sync_en_i,
    input  logic [2:0]            ring_en_i,
    output logic                  start_o,
    output logic [1:0]            act_voice_o,
    output logic [FREQ_W-1:0]     freq_word_o,
    output logic [PW_W-1:0]       pw_word_o,
    output logic [WSEL_W-1:0]     wave_sel_o,
    output logic                  sync_o,
    output logic                  ring_mod_o,
    input  logic                  ready_i,
    input  logic [VOICE_W-1:0]    wave_i,
    output logic [MIX_W-1:0]      mix_o,
    output logic                  mix_valid_o,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  timeout_o
);

    localparam logic [1:0] LAST_VOICE = 2'(NUM_VOICES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    seq_state_e               state_q, state_d;
    logic [1:0]               idx_q, idx_d;
    logic [7:0]               cnt_q, cnt_d;
    logic signed [MIX_W-1:0]  acc_q, acc_d;
    logic [MIX_W-1:0]         mix_q, mix_d;
    logic                     mix_vld_q, mix_vld_d;

    logic                     wait_live;
    logic                     tmo_hit;
    logic                     take;
    logic                     adv;
    logic signed [MIX_W-1:0]  adv_val;
    logic signed [MIX_W-1:0]  acc_sum;
    logic signed [MIX_W-1:0]  wave_ext;

    assign wave_ext = {{(MIX_W-VOICE_W){wave_i[VOICE_W-1]}}, wave_i};

`ifdef VOICE_GAIN_EN
    logic                     pend_q;
    logic signed [MIX_W-1:0]  prod_q;
    logic [WSEL_W-1:0]        gain;
    logic signed [14:0]       prod_full;
    logic signed [MIX_W-1:0]  scaled;

    assign gain      = gains_i[{idx_q, 2'b00} +: WSEL_W];
    assign prod_full = $signed({{5{wave_i[VOICE_W-1]}}, wave_i}) * $signed({10'd0, gain});
    // (wave * gain) >>> 4; magnitude stays within 480 so the top bits are pure sign.
    assign scaled    = {prod_full[14], prod_full[14:4]};

    assign wait_live = (state_q == S_WAIT) && !pend_q;
    assign adv       = pend_q;
    assign adv_val   = prod_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            prod_q <= '0;
        end else if (take) begin
            pend_q <= 1'b1;
            prod_q <= ready_i ? scaled : '0;
        end else begin
            pend_q <= 1'b0;
        end
    end
`else
    assign wait_live = (state_q == S_WAIT);
    assign adv       = take;
    assign adv_val   = ready_i ? wave_ext : '0;
`endif

    // Ready on the final allowed cycle beats the timeout.
    assign tmo_hit   = wait_live && !ready_i && (cnt_q == TMO_LAST);
    assign take      = wait_live && (ready_i || (cnt_q == TMO_LAST));
    assign acc_sum   = acc_q + adv_val;

    assign start_o     = (state_q == S_ISSUE);
    assign busy_o      = (state_q != S_IDLE);
    assign overrun_o   = sample_tick_i && busy_o;
    assign timeout_o   = tmo_hit;
    assign act_voice_o = idx_q;
    assign mix_o       = mix_q;
    assign mix_valid_o = mix_vld_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mix_d     = mix_q;
        mix_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_tick_i) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (adv) begin
                    if (idx_q == LAST_VOICE) begin
                        mix_d     = acc_sum;
                        mix_vld_d = 1'b1;
                        idx_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        acc_d   = acc_sum;
                        idx_d   = idx_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mix_q     <= '0;
            mix_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mix_q     <= mix_d;
            mix_vld_q <= mix_vld_d;
        end
    end

    voice_param_mux u_mux (
        .en_i         (busy_o),
        .idx_i        (idx_q),
        .freq_words_i (freq_words_i),
        .pw_words_i   (pw_words_i),
        .wave_sels_i  (wave_sels_i),
        .sync_en_i    (sync_en_i),
        .ring_en_i    (ring_en_i),
        .freq_word_o  (freq_word_o),
        .pw_word_o    (pw_word_o),
        .wave_sel_o   (wave_sel_o),
        .sync_o       (sync_o),
        .ring_mod_o   (ring_mod_o)
    );

endmodule

// File: tb/tb_voice_sequencer.sv
// Randomized bench for voice_sequencer: a behavioural generator responder plus a per-tick
// expectation of mix value, completion cycle, start/timeout/overrun counts (honours VOICE_GAIN_EN).
module tb_voice_sequencer;

    localparam int NV = 3;
    localparam int T  = 15;
`ifdef VOICE_GAIN_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sample_tick_i;
    logic [47:0] freq_words_i;
    logic [35:0] pw_words_i;
    logic [11:0] wave_sels_i;
    logic [2:0]  sync_en_i;
    logic [2:0]  ring_en_i;
    logic        start_o;
    logic [1:0]  act_voice_o;
    logic [15:0] freq_word_o;
    logic [11:0] pw_word_o;
    logic [3:0]  wave_sel_o;
    logic        sync_o;
    logic        ring_mod_o;
    logic        ready_i;
    logic [9:0]  wave_i;
    logic [11:0] mix_o;
    logic        mix_valid_o;
    logic        busy_o;
    logic        overrun_o;
    logic        timeout_o;
`ifdef VOICE_GAIN_EN
    logic [11:0] gains_i;
`endif

    always #10 clk_i = ~clk_i;

    voice_sequencer #(.NUM_VOICES(NV), .TIMEOUT_CYCLES(T)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
`ifdef VOICE_GAIN_EN
        .gains_i       (gains_i),
`endif
        .sample_tick_i (sample_tick_i),
        .freq_words_i  (freq_words_i),
        .pw_words_i    (pw_words_i),
        .wave_sels_i   (wave_sels_i),
        .sync_en_i     (sync_en_i),
        .ring_en_i     (ring_en_i),
        .start_o       (start_o),
        .act_voice_o   (act_voice_o),
        .freq_word_o   (freq_word_o),
        .pw_word_o     (pw_word_o),
        .wave_sel_o    (wave_sel_o),
        .sync_o        (sync_o),
        .ring_mod_o    (ring_mod_o),
        .ready_i       (ready_i),
        .wave_i        (wave_i),
        .mix_o         (mix_o),
        .mix_valid_o   (mix_valid_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o),
        .timeout_o     (timeout_o)
    );

    int total = 0;
    int bad   = 0;
    // dly[v]: cycles from start to ready (0 = generator never answers)
    int dly [NV];
    int wav [NV];
    int gn  [NV];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int voice_contrib(input int v);
`ifdef VOICE_GAIN_EN
        return (wav[v] * gn[v]) >>> 4;
`else
        return wav[v];
`endif
    endfunction

    function automatic logic [52:0] all_outs();
        return {start_o, act_voice_o, freq_word_o, pw_word_o, wave_sel_o, sync_o,
                ring_mod_o, mix_o, mix_valid_o, busy_o, overrun_o, timeout_o};
    endfunction

    // Generator model: answers dly cycles after start, also throws stray readys at idle/issue.
    int         rcnt = 0;
    logic [1:0] rv   = 2'd0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            rcnt    = 0;
            ready_i = 1'b0;
            wave_i  = '0;
        end else begin
            ready_i = 1'b0;
            wave_i  = 10'($urandom);
            if (start_o) begin
                rv   = act_voice_o;
                rcnt = dly[act_voice_o];
                if ($urandom_range(0, 3) == 0) ready_i = 1'b1;
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    ready_i = 1'b1;
                    wave_i  = 10'(wav[rv]);
                end
            end else if (!busy_o && $urandom_range(0, 7) == 0) begin
                ready_i = 1'b1;
            end
        end
    end

    task automatic randomize_ctl();
        freq_words_i = 48'({$urandom(), $urandom()});
        pw_words_i   = 36'({$urandom(), $urandom()});
        for (int v = 0; v < NV; v++)
            wave_sels_i[4*v +: 4] = 4'(1 << $urandom_range(0, 3));
        sync_en_i = 3'($urandom());
        ring_en_i = 3'($urandom());
`ifdef VOICE_GAIN_EN
        gains_i = 12'($urandom());
        for (int v = 0; v < NV; v++) gn[v] = int'(gains_i[4*v +: 4]);
`endif
    endtask

    // One tick; ov_at = relative cycle of a second tick (-1 none, == completion cycle for back-to-back).
    task automatic run_tick(input int ov_at);
        int lat, mixe, tmoe, nst, ntmo, novr, nvld, glat, gmix, b2b;
        lat = 1; mixe = 0; tmoe = 0;
        for (int v = 0; v < NV; v++) begin
            if (dly[v] >= 1 && dly[v] <= T) begin
                lat  += 1 + dly[v] + G;
                mixe += voice_contrib(v);
            end else begin
                lat  += 1 + T + G;
                tmoe++;
            end
        end
        b2b = (ov_at == lat) ? 1 : 0;
        nst = 0; ntmo = 0; novr = 0; nvld = 0; glat = -1; gmix = 0;
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        #1;
        check_val("idle_before_tick", {busy_o, overrun_o}, 0);
        for (int k = 1; k <= lat + 4; k++) begin
            @(negedge clk_i);
            sample_tick_i = (k == ov_at);
            #1;
            if (k <= lat) begin
                if (start_o) begin
                    check_val("act_voice", act_voice_o, nst);
                    check_val("ctl_words",
                        {freq_word_o, pw_word_o, wave_sel_o, sync_o, ring_mod_o},
                        {freq_words_i[16*nst +: 16], pw_words_i[12*nst +: 12],
                         wave_sels_i[4*nst +: 4], sync_en_i[nst], ring_en_i[nst]});
                    nst++;
                end
                if (timeout_o) ntmo++;
            end
            if (overrun_o) novr++;
            if (b2b == 1 && k == lat + 1) check_val("b2b_start", start_o, 1);
            if (mix_valid_o) begin
                nvld++;
                if (glat < 0) begin
                    glat = k;
                    gmix = int'($signed(mix_o));
                end
            end
        end
        check_val("latency", glat, lat);
        check_val("mix", gmix, mixe);
        check_val("starts", nst, NV);
        check_val("timeouts", ntmo, tmoe);
        check_val("overruns", novr, (ov_at >= 1 && ov_at < lat) ? 1 : 0);
        check_val("valid_count", nvld, 1);
        if (b2b == 1) begin
            for (int k = 0; k < 200 && busy_o; k++) @(negedge clk_i);
            #1;
        end
        check_val("idle_after", busy_o, 0);
    endtask

    task automatic reset_mid();
        int nvld;
        nvld = 0;
        for (int v = 0; v < NV; v++) begin
            dly[v] = 3;
            wav[v] = $urandom_range(0, 1023) - 512;
        end
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i);
            sample_tick_i = 1'b0;
            #1;
            if (mix_valid_o) nvld++;
        end
        check_val("pre_rst_voice1", {busy_o, act_voice_o}, {1'b1, 2'd1});
        rst_ni = 1'b0;
        #1;
        check_val("rst_mid_outs", all_outs(), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            #1;
            if (mix_valid_o) nvld++;
        end
        check_val("rst_no_valid", nvld, 0);
        check_val("rst_idle", busy_o, 0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        sample_tick_i = 1'b0;
        ready_i       = 1'b0;
        wave_i        = '0;
        for (int v = 0; v < NV; v++) begin
            dly[v] = 3;
            wav[v] = 0;
            gn[v]  = 16;
        end
        randomize_ctl();
`ifndef VOICE_GAIN_EN
        for (int v = 0; v < NV; v++) gn[v] = 16;
`endif
        repeat (2) @(negedge clk_i);
        #1;
        check_val("reset_outs", all_outs(), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

`ifdef VOICE_GAIN_EN
        gains_i = {4'd0, 4'd8, 4'd15};
        gn[0] = 15; gn[1] = 8; gn[2] = 0;
        wav[0] = 511; wav[1] = -512; wav[2] = 300;
        run_tick(-1);
        gains_i = 12'hfff;
        for (int v = 0; v < NV; v++) gn[v] = 15;
`endif

        wav[0] = 100; wav[1] = -200; wav[2] = 50;
        run_tick(-1);

        for (int v = 0; v < NV; v++) wav[v] = -512;
        run_tick(-1);
        for (int v = 0; v < NV; v++) wav[v] = 511;
        run_tick(-1);

        wav[0] = 7; wav[1] = 300; wav[2] = -9;
        dly[1] = 0;
        run_tick(-1);

        dly[0] = 3; dly[1] = 3; dly[2] = 3;
        run_tick(5);

        dly[0] = T; dly[1] = 2; dly[2] = 1;
        run_tick(-1);

        dly[0] = 3; dly[1] = 3; dly[2] = 3;
        run_tick(1 + NV * (4 + G));

        reset_mid();
        wav[0] = -77; wav[1] = 123; wav[2] = 400;
        run_tick(-1);

        for (int n = 0; n < 25; n++) begin
            randomize_ctl();
            for (int v = 0; v < NV; v++) begin
                int r;
                wav[v] = $urandom_range(0, 1023) - 512;
                r = $urandom_range(0, 9);
                if (r == 0)      dly[v] = 0;
                else if (r == 1) dly[v] = T;
                else             dly[v] = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 3) == 0) run_tick($urandom_range(2, 6));
            else                           run_tick(-1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
